// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-way intersection controller:
//   - state_e     : controller phase (N_GREEN, Y_TO_E, E_GREEN, Y_TO_N)
//   - LAMP_*      : one-hot lamp patterns (001 green, 010 yellow, 100 red)
//   - SEG_BLANK   : active-low seven-segment pattern with every segment off
//   - lamps()     : phase -> {north lamp, east lamp}
//   - to_bcd()    : value -> {tens, units} BCD, clamped to 99
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    N_GREEN = 2'd0,
    Y_TO_E  = 2'd1,
    E_GREEN = 2'd2,
    Y_TO_N  = 2'd3
  } state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Lamp pair for a phase; anything unexpected shows the reset pattern so
  // the two approaches can never both be green.
  function automatic logic [5:0] lamps(input state_e s);
    logic [5:0] l;
    case (s)
      N_GREEN: l = {LAMP_GREEN, LAMP_RED};
      Y_TO_E:  l = {LAMP_YELLOW, LAMP_YELLOW};
      E_GREEN: l = {LAMP_RED, LAMP_GREEN};
      Y_TO_N:  l = {LAMP_YELLOW, LAMP_YELLOW};
      default: l = {LAMP_GREEN, LAMP_RED};
    endcase
    return l;
  endfunction

  // Two BCD digits {tens, units}; values above 99 saturate at 99.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 32'd99) ? 32'd99 : v;
    return {4'(c / 32'd10), 4'(c % 32'd10)};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational decimal digit to active-low seven-segment pattern.
//   digit_i [3:0] : digit 0..9 (other codes blank the display)
//   seg_o   [6:0] : segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Digit lookup.
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/traffic_light.sv
// ---------------------------------------------------------------------------
// traffic_light
// Two-way (North/East) intersection controller with minimum green time and
// an all-yellow phase on every change of right of way.
//
// Build option: define COUNTDOWN_DISPLAY_EN to drive HEX1/HEX0 with the
// seconds remaining in the current phase; otherwise both displays are blank.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   KEY        in   asynchronous active-low reset
//   SW[1:0]    in   car present (SW[0]=North, SW[1]=East), asynchronous
//   LED_N[2:0] out  North lamp, one-hot 001 green / 010 yellow / 100 red
//   LED_E[2:0] out  East lamp, same encoding
//   HEX0[6:0]  out  countdown units digit, active-low {g,f,e,d,c,b,a}
//   HEX1[6:0]  out  countdown tens digit, same format
// ---------------------------------------------------------------------------
module traffic_light
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_MAX    = 50_000_000,
  parameter int unsigned GREEN_SEC  = 30,
  parameter int unsigned YELLOW_SEC = 3
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic [1:0] SW,
  output logic [2:0] LED_N,
  output logic [2:0] LED_E,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int unsigned PRE_W = $clog2(CNT_MAX + 1);
  localparam int unsigned SEC_W = $clog2(GREEN_SEC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT_MAX - 1);
  localparam logic [SEC_W-1:0] GREEN_S  = SEC_W'(GREEN_SEC);
  localparam logic [SEC_W-1:0] YELLOW_S = SEC_W'(YELLOW_SEC);

  logic [1:0]       sw_meta_q;
  logic [1:0]       sw_sync_q;
  state_e           state_q;
  state_e           state_d;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;
  logic [SEC_W-1:0] sec_q;
  logic [SEC_W-1:0] sec_d;
  logic [SEC_W-1:0] sec_inc_s;
  logic             tick_s;
  logic [2:0]       led_n_q;
  logic [2:0]       led_e_q;

  // Two-flop synchronizer for the car-present switches.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      sw_meta_q <= 2'b00;
      sw_sync_q <= 2'b00;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Tick detection and the saturating seconds value after this cycle.
  always_comb begin
    tick_s    = (presc_q == PRE_LAST);
    sec_inc_s = sec_q;
    if (tick_s && (sec_q != GREEN_S)) begin
      sec_inc_s = sec_q + SEC_W'(1);
    end else begin
      sec_inc_s = sec_q;
    end
  end

  // Phase transitions. Decisions look at the seconds count as it will be
  // after this edge so a phase lasts exactly N ticks, not N ticks plus one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      N_GREEN: begin
        if ((sec_inc_s >= GREEN_S) && sw_sync_q[1]) begin
          state_d = Y_TO_E;
        end else begin
          state_d = N_GREEN;
        end
      end
      Y_TO_E: begin
        if (sec_inc_s == YELLOW_S) begin
          state_d = E_GREEN;
        end else begin
          state_d = Y_TO_E;
        end
      end
      E_GREEN: begin
        if ((sec_inc_s >= GREEN_S) && sw_sync_q[0]) begin
          state_d = Y_TO_N;
        end else begin
          state_d = E_GREEN;
        end
      end
      Y_TO_N: begin
        if (sec_inc_s == YELLOW_S) begin
          state_d = N_GREEN;
        end else begin
          state_d = Y_TO_N;
        end
      end
      default: state_d = N_GREEN;
    endcase
  end

  // Prescaler and seconds counter; both restart on every phase entry.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (state_d != state_q) begin
      presc_d = '0;
      sec_d   = '0;
    end else begin
      presc_d = tick_s ? '0 : (presc_q + PRE_W'(1));
      sec_d   = sec_inc_s;
    end
  end

  // Phase, counters and lamp registers. Lamps are loaded from the next
  // phase so they change on the same edge as the phase itself.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q <= N_GREEN;
      presc_q <= '0;
      sec_q   <= '0;
      led_n_q <= LAMP_GREEN;
      led_e_q <= LAMP_RED;
    end else begin
      state_q            <= state_d;
      presc_q            <= presc_d;
      sec_q              <= sec_d;
      {led_n_q, led_e_q} <= lamps(state_d);
    end
  end

  assign LED_N = led_n_q;
  assign LED_E = led_e_q;

`ifdef COUNTDOWN_DISPLAY_EN
  logic [7:0]  bcd_q;
  int unsigned rem_s;

  // Seconds remaining in the phase being entered/held, floored at zero.
  always_comb begin
    rem_s = 32'd0;
    case (state_d)
      N_GREEN, E_GREEN: begin
        if (32'(sec_d) >= GREEN_SEC) begin
          rem_s = 32'd0;
        end else begin
          rem_s = GREEN_SEC - 32'(sec_d);
        end
      end
      Y_TO_E, Y_TO_N: begin
        if (32'(sec_d) >= YELLOW_SEC) begin
          rem_s = 32'd0;
        end else begin
          rem_s = YELLOW_SEC - 32'(sec_d);
        end
      end
      default: rem_s = GREEN_SEC;
    endcase
  end

  // Countdown digits, updated on the same edge as the seconds counter.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      bcd_q <= to_bcd(GREEN_SEC);
    end else begin
      bcd_q <= to_bcd(rem_s);
    end
  end

  seg7_decoder u_seg_units (
    .digit_i (bcd_q[3:0]),
    .seg_o   (HEX0)
  );

  seg7_decoder u_seg_tens (
    .digit_i (bcd_q[7:4]),
    .seg_o   (HEX1)
  );
`else
  assign HEX0 = SEG_BLANK;
  assign HEX1 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_traffic_light.sv
// ---------------------------------------------------------------------------
// tb_traffic_light
// Self-checking bench for traffic_light with CNT_MAX=5 (1 s = 5 cycles).
// A cycle-level reference model tracks the phase and the number of clock
// edges spent in it, and derives lamps and countdown from those.
// ---------------------------------------------------------------------------
module tb_traffic_light;

  localparam int CNT = 5;
  localparam int GS  = 30;
  localparam int YS  = 3;

  localparam int PH_NG = 0;
  localparam int PH_YE = 1;
  localparam int PH_EG = 2;
  localparam int PH_YN = 3;

  logic       clk = 1'b0;
  logic       key;
  logic [1:0] sw;
  logic [2:0] LED_N;
  logic [2:0] LED_E;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_phase;
  int         m_cyc;
  logic [1:0] m_meta;
  logic [1:0] m_sync;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  traffic_light #(
    .CNT_MAX    (CNT),
    .GREEN_SEC  (GS),
    .YELLOW_SEC (YS)
  ) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LED_N    (LED_N),
    .LED_E    (LED_E),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    m_phase = PH_NG;
    m_cyc   = 0;
    m_meta  = 2'b00;
    m_sync  = 2'b00;
  endtask

  // One clock edge of the reference: request seen two edges late, green
  // yields once at least GS*CNT edges have passed, yellow lasts YS*CNT edges.
  task automatic model_edge();
    logic [1:0] req;
    int         n;
    int         nxt;
    req    = m_sync;
    m_sync = m_meta;
    m_meta = sw;
    n      = m_cyc + 1;
    nxt    = m_phase;
    if (m_phase == PH_NG && n >= GS * CNT && req[1]) nxt = PH_YE;
    if (m_phase == PH_EG && n >= GS * CNT && req[0]) nxt = PH_YN;
    if (m_phase == PH_YE && n == YS * CNT) nxt = PH_EG;
    if (m_phase == PH_YN && n == YS * CNT) nxt = PH_NG;
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_cyc   = 0;
    end else begin
      m_cyc = n;
    end
  endtask

  // Expected {LED_N, LED_E, HEX1, HEX0} from the model.
  function automatic logic [19:0] exp_out();
    logic [2:0] n;
    logic [2:0] e;
    logic [13:0] h;
    int sec;
    int rem;
    n = (m_phase == PH_NG) ? 3'b001 : (m_phase == PH_EG) ? 3'b100 : 3'b010;
    e = (m_phase == PH_NG) ? 3'b100 : (m_phase == PH_EG) ? 3'b001 : 3'b010;
    sec = m_cyc / CNT;
    if (sec > GS) sec = GS;
`ifdef COUNTDOWN_DISPLAY_EN
    if (m_phase == PH_NG || m_phase == PH_EG) rem = (GS > sec) ? GS - sec : 0;
    else rem = (YS > sec) ? YS - sec : 0;
    if (rem > 99) rem = 99;
    h = {seg_tab[rem / 10], seg_tab[rem % 10]};
`else
    rem = sec;
    h = {7'h7F, 7'h7F};
`endif
    return {n, e, h};
  endfunction

  // Advance one clock edge (model follows) and settle for sampling.
  task automatic step();
    @(posedge clk);
    if (!key) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    key = 1'b0;
    model_reset();
    step();
    step();
    key = 1'b1;
  endtask

  task automatic test_reset();
    sw  = 2'b00;
    key = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({LED_N, LED_E} !== 6'b001_100) begin
        errors++;
        $display("FAIL reset_lamps: got N=%b E=%b expected N=001 E=100", LED_N, LED_E);
      end
    end
    checks++;
`ifdef COUNTDOWN_DISPLAY_EN
    if ({HEX1, HEX0} !== {seg_tab[3], seg_tab[0]}) begin
`else
    if ({HEX1, HEX0} !== {7'h7F, 7'h7F}) begin
`endif
      errors++;
      $display("FAIL reset_hex: got %b_%b", HEX1, HEX0);
    end
    key = 1'b1;
    step();
    checks++;
    if ({LED_N, LED_E, HEX1, HEX0} !== exp_out()) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", {LED_N, LED_E, HEX1, HEX0}, exp_out());
    end
  endtask

  task automatic test_no_demand();
    do_reset();
    sw = 2'b00;
    for (int i = 0; i < 250; i++) begin
      step();
      checks++;
      if ({LED_N, LED_E, HEX1, HEX0} !== exp_out() || {LED_N, LED_E} !== 6'b001_100) begin
        errors++;
        $display("FAIL no_demand cyc %0d: got %h expected %h", i, {LED_N, LED_E, HEX1, HEX0}, exp_out());
      end
    end
  endtask

  task automatic test_east_request();
    int first_yel;
    int yel_cnt;
    first_yel = -1;
    yel_cnt   = 0;
    do_reset();
    sw = 2'b00;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i == 35) sw = 2'b10;
      if (LED_N == 3'b010 && LED_E == 3'b010) begin
        yel_cnt++;
        if (first_yel < 0) first_yel = i;
      end
      checks++;
      if ({LED_N, LED_E, HEX1, HEX0} !== exp_out()) begin
        errors++;
        $display("FAIL east_req cyc %0d: got %h expected %h", i, {LED_N, LED_E, HEX1, HEX0}, exp_out());
      end
    end
    checks++;
    if (first_yel !== GS * CNT) begin
      errors++;
      $display("FAIL east_green_hold: yellow at cycle %0d expected %0d", first_yel, GS * CNT);
    end
    checks++;
    if (yel_cnt !== YS * CNT) begin
      errors++;
      $display("FAIL east_yellow_len: %0d cycles expected %0d", yel_cnt, YS * CNT);
    end
    checks++;
    if ({LED_N, LED_E} !== 6'b100_001) begin
      errors++;
      $display("FAIL east_green: got N=%b E=%b expected N=100 E=001", LED_N, LED_E);
    end
  endtask

  task automatic test_late_request();
    bit seen;
    do_reset();
    sw = 2'b00;
    for (int i = 0; i < 200; i++) step();
    sw   = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      step();
      if (LED_N == 3'b010 && LED_E == 3'b010) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL late_request: no yellow within 3 cycles, N=%b E=%b", LED_N, LED_E);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({LED_N, LED_E, HEX1, HEX0} !== exp_out()) begin
        errors++;
        $display("FAIL late_follow cyc %0d: got %h expected %h", i, {LED_N, LED_E, HEX1, HEX0}, exp_out());
      end
    end
  endtask

  task automatic test_both_random();
    do_reset();
    sw = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 700 && (i % 40) == 0) sw = 2'($urandom_range(0, 3));
      step();
      checks++;
      if ({LED_N, LED_E, HEX1, HEX0} !== exp_out() || (LED_N == 3'b001 && LED_E == 3'b001)) begin
        errors++;
        $display("FAIL random cyc %0d sw=%b: got %h expected %h", i, sw, {LED_N, LED_E, HEX1, HEX0}, exp_out());
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int first_yel;
    do_reset();
    sw   = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (LED_N == 3'b010 && LED_E == 3'b010) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reset_setup: never reached yellow");
    end
    step();
    step();
    #3;
    key = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({LED_N, LED_E} !== 6'b001_100) begin
      errors++;
      $display("FAIL mid_reset_async: got N=%b E=%b expected N=001 E=100", LED_N, LED_E);
    end
    step();
    key = 1'b1;
    first_yel = -1;
    for (int i = 1; i <= 160; i++) begin
      step();
      if (first_yel < 0 && LED_N == 3'b010) first_yel = i;
      checks++;
      if ({LED_N, LED_E, HEX1, HEX0} !== exp_out()) begin
        errors++;
        $display("FAIL mid_reset_follow cyc %0d: got %h expected %h", i, {LED_N, LED_E, HEX1, HEX0}, exp_out());
      end
    end
    checks++;
    if (first_yel !== GS * CNT) begin
      errors++;
      $display("FAIL mid_reset_restart: yellow at cycle %0d expected %0d", first_yel, GS * CNT);
    end
  endtask

  initial begin
    sw  = 2'b00;
    key = 1'b0;
    test_reset();
    test_no_demand();
    test_east_request();
    test_late_request();
    test_both_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
